// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter:
// FSM states, request owners and the RAM base.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_t;

   localparam logic [63:0] BASE_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant,
// pointer remembers the last requester actually served.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_if,
   input  logic req_ls,
   input  logic take,
   output logic gnt_if,
   output logic gnt_ls
);

   owner_t last_q;

   always_comb begin
      gnt_if = 1'b0;
      gnt_ls = 1'b0;
      if (req_if && req_ls) begin
         if (last_q == OWN_IF) gnt_ls = 1'b1;
         else                  gnt_if = 1'b1;
      end else begin
         gnt_if = req_if;
         gnt_ls = req_ls;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= OWN_IF;
      end else if (take) begin
         last_q <= gnt_ls ? OWN_LS : OWN_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one
// shared RAM port with a fixed four-cycle transaction.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          WIDTH = 64,
   parameter logic [WIDTH-1:0] BASE = WIDTH'(BASE_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req_valid,
   output logic             if_req_ready,
   input  logic [WIDTH-1:0] if_req_addr,
   output logic             if_resp_valid,
   output logic [31:0]      if_resp_data,
   output logic             if_resp_err,
   input  logic             ls_req_valid,
   output logic             ls_req_ready,
   input  logic [WIDTH-1:0] ls_req_addr,
   input  logic             ls_req_wen,
   input  logic [WIDTH-1:0] ls_req_wdata,
   input  logic [WIDTH-1:0] ls_req_wmask,
   output logic             ls_resp_valid,
   output logic [WIDTH-1:0] ls_resp_rdata,
   output logic             ls_resp_err,
   output logic             mem_en,
   output logic [WIDTH-1:0] mem_idx,
   output logic             mem_wen,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [WIDTH-1:0] mem_wmask,
   input  logic [WIDTH-1:0] mem_rdata
);

   state_t           state_q;
   state_t           state_d;
   owner_t           owner_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] wmask_q;
   logic [WIDTH-1:0] rdata_q;
   logic             wen_q;
   logic             err_q;

   logic             gnt_if;
   logic             gnt_ls;
   logic             take;
   logic             idle;
   logic             resp;
   logic [WIDTH-1:0] addr_sel;

   rr_arb2 u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_if (if_req_valid),
      .req_ls (ls_req_valid),
      .take   (take),
      .gnt_if (gnt_if),
      .gnt_ls (gnt_ls)
   );

   // rst_n gating keeps ready low while reset is held
   assign idle         = (state_q == IDLE) & rst_n;
   assign if_req_ready = idle & gnt_if;
   assign ls_req_ready = idle & gnt_ls;
   assign take         = (if_req_valid & if_req_ready)
                       | (ls_req_valid & ls_req_ready);
   assign addr_sel     = gnt_ls ? ls_req_addr : if_req_addr;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (take) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_IF;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (take) begin
            owner_q <= gnt_ls ? OWN_LS : OWN_IF;
            addr_q  <= addr_sel;
            wdata_q <= ls_req_wdata;
            wmask_q <= ls_req_wmask;
            wen_q   <= gnt_ls & ls_req_wen;
            err_q   <= addr_sel < BASE;
         end
         if (state_q == WAIT) rdata_q <= mem_rdata;
      end
   end

   assign mem_en    = (state_q == ISSUE) & ~err_q;
   assign mem_idx   = mem_en ? ((addr_q - BASE) >> 3) : '0;
   assign mem_wen   = mem_en & wen_q;
   assign mem_wdata = mem_wen ? wdata_q : '0;
   assign mem_wmask = mem_wen ? wmask_q : '0;

   // Response fields stay zero outside the single RESP cycle
   assign resp          = state_q == RESP;
   assign if_resp_valid = resp & (owner_q == OWN_IF);
   assign ls_resp_valid = resp & (owner_q == OWN_LS);
   assign if_resp_err   = if_resp_valid & err_q;
   assign ls_resp_err   = ls_resp_valid & err_q;

   assign if_resp_data  = (if_resp_valid & ~err_q)
                        ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0])
                        : '0;
   assign ls_resp_rdata = (ls_resp_valid & ~err_q & ~wen_q)
                        ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter
// with a word-array reference model of the RAM.
module tb_mem_port_arbiter;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [63:0] if_req_addr = '0;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        if_resp_err;
   logic        ls_req_valid = 1'b0;
   logic        ls_req_ready;
   logic [63:0] ls_req_addr = '0;
   logic        ls_req_wen = 1'b0;
   logic [63:0] ls_req_wdata = '0;
   logic [63:0] ls_req_wmask = '0;
   logic        ls_resp_valid;
   logic [63:0] ls_resp_rdata;
   logic        ls_resp_err;
   logic        mem_en;
   logic [63:0] mem_idx;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [63:0] mem_wmask;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(64), .BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
      .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .if_resp_err(if_resp_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
      .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
      .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
      .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
      .ls_resp_err(ls_resp_err),
      .mem_en(mem_en), .mem_idx(mem_idx), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      int          cyc;
      logic [63:0] idx;
      logic        wen;
      logic [63:0] wdata;
      logic [63:0] wmask;
   } mem_exp_t;

   typedef struct {
      int          cyc;
      bit          own_ls;
      logic [63:0] data;
      logic        err;
   } resp_exp_t;

   mem_exp_t  mem_q[$];
   resp_exp_t resp_q[$];
   int        checks = 0;
   int        errors = 0;
   int        cyc = 0;
   bit        last_ls = 1'b0;
   logic [63:0] ram[logic [63:0]];
   logic [63:0] ref_mem[logic [63:0]];
   logic [63:0] old_w;
   mem_exp_t  me;
   resp_exp_t re;

   function automatic logic [63:0] init_word(logic [63:0] idx);
      if (idx == 64'h0) return 64'hAAAA_BBBB_CCCC_DDDD;
      return {idx[31:0] ^ 32'h5A5A_0000, ~idx[31:0]};
   endfunction

   function automatic logic [63:0] ref_rd(logic [63:0] idx);
      if (ref_mem.exists(idx)) return ref_mem[idx];
      return init_word(idx);
   endfunction

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      if ($urandom_range(0, 9) == 0) begin
         a = BASE - (64'($urandom_range(1, 4)) << 3);
      end else begin
         a = BASE + (64'($urandom_range(0, 15)) << 3);
      end
      return a + (64'($urandom_range(0, 1)) << 2);
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  name, got, exp, cyc);
      end
   endtask

   // Behavioural RAM answering the DUT, one-cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en) begin
         old_w = ram.exists(mem_idx) ? ram[mem_idx] : init_word(mem_idx);
         mem_rdata <= old_w;
         if (mem_wen) begin
            ram[mem_idx] = (old_w & ~mem_wmask) | (mem_wdata & mem_wmask);
         end
      end
   end

   always @(negedge clk) begin
      if (mem_q.size() != 0 && mem_q[0].cyc == cyc) begin
         me = mem_q.pop_front();
         chk("mem_en", 64'(mem_en), 64'd1);
         chk("mem_idx", mem_idx, me.idx);
         chk("mem_wen", 64'(mem_wen), 64'(me.wen));
         chk("mem_wdata", mem_wdata, me.wdata);
         chk("mem_wmask", mem_wmask, me.wmask);
      end else if (mem_en) begin
         chk("mem_en_unexpected", 64'(mem_en), 64'd0);
      end
      if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
         re = resp_q.pop_front();
         chk("if_resp_valid", 64'(if_resp_valid), 64'(!re.own_ls));
         chk("ls_resp_valid", 64'(ls_resp_valid), 64'(re.own_ls));
         if (re.own_ls) begin
            chk("ls_resp_rdata", ls_resp_rdata, re.data);
            chk("ls_resp_err", 64'(ls_resp_err), 64'(re.err));
         end else begin
            chk("if_resp_data", 64'(if_resp_data), re.data);
            chk("if_resp_err", 64'(if_resp_err), 64'(re.err));
         end
      end else if (if_resp_valid || ls_resp_valid) begin
         chk("resp_unexpected",
             {62'b0, if_resp_valid, ls_resp_valid}, 64'd0);
      end
      if (!if_resp_valid) begin
         chk("if_resp_idle_zero",
             {31'b0, if_resp_err, if_resp_data}, 64'd0);
      end
      if (!ls_resp_valid) begin
         chk("ls_resp_idle_zero",
             ls_resp_rdata | 64'(ls_resp_err), 64'd0);
      end
   end

   task automatic issue(input bit vi, input bit vl,
                        input logic [63:0] ia, input logic [63:0] la,
                        input bit wen, input logic [63:0] wd,
                        input logic [63:0] wm);
      bit          w_ls;
      bit          st;
      int          t;
      logic [63:0] a;
      logic [63:0] idx;
      logic [63:0] word;
      logic [63:0] d;
      logic        err;
      @(negedge clk);
      if_req_valid = vi;
      if_req_addr  = ia;
      ls_req_valid = vl;
      ls_req_addr  = la;
      ls_req_wen   = wen;
      ls_req_wdata = wd;
      ls_req_wmask = wm;
      #1;
      w_ls = (vi && vl) ? !last_ls : vl;
      chk("if_req_ready", 64'(if_req_ready), 64'(!w_ls));
      chk("ls_req_ready", 64'(ls_req_ready), 64'(w_ls));
      t       = cyc;
      last_ls = w_ls;
      a       = w_ls ? la : ia;
      err     = a < BASE;
      idx     = (a - BASE) >> 3;
      word    = ref_rd(idx);
      st      = w_ls && wen;
      if (!err) begin
         mem_q.push_back('{cyc: t + 1, idx: idx, wen: st,
                           wdata: st ? wd : 64'h0,
                           wmask: st ? wm : 64'h0});
      end
      if (err) d = 64'h0;
      else if (w_ls) d = wen ? 64'h0 : word;
      else d = a[2] ? {32'b0, word[63:32]} : {32'b0, word[31:0]};
      resp_q.push_back('{cyc: t + 3, own_ls: w_ls, data: d, err: err});
      if (st && !err) ref_mem[idx] = (word & ~wm) | (wd & wm);
      @(posedge clk);
      #1;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      if_req_addr  = rand_addr();
      ls_req_addr  = rand_addr();
      ls_req_wen   = 1'($urandom);
      ls_req_wdata = {$urandom, $urandom};
      ls_req_wmask = {$urandom, $urandom};
   endtask

   task automatic round(input bit vi, input bit vl,
                        input logic [63:0] ia, input logic [63:0] la,
                        input bit wen, input logic [63:0] wd,
                        input logic [63:0] wm);
      issue(vi, vl, ia, la, wen, wd, wm);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_all_zero(string name);
      chk({name, "_ctl"},
          {56'b0, if_req_ready, ls_req_ready, if_resp_valid,
           ls_resp_valid, mem_en, mem_wen, if_resp_err, ls_resp_err},
          64'd0);
      chk({name, "_mem"}, mem_idx | mem_wdata | mem_wmask, 64'd0);
      chk({name, "_data"}, ls_resp_rdata | 64'(if_resp_data), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      repeat (2) @(negedge clk);
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      #1;
      chk_all_zero("reset");
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      round(1, 1, BASE + 64'h4, BASE + 64'h10, 1, 64'h1234, '1);
      round(1, 1, BASE + 64'h4, BASE + 64'h10, 0, 64'h0, '1);
      round(1, 1, BASE + 64'h0, BASE + 64'h10, 0, 64'h0, '1);
      round(1, 1, BASE + 64'h8, BASE + 64'h18, 0, 64'h0, '1);
      round(0, 1, BASE, 64'h7FFF_FFF8, 0, 64'h0, '1);
      round(1, 0, 64'h7FFF_FFFC, BASE, 0, 64'h0, '1);
      round(0, 1, BASE, 64'h7FFF_FFF0, 1, 64'hFFFF, '1);

      for (int i = 0; i < 200; i++) begin
         p = $urandom_range(0, 2);
         round(p != 1, p != 0, rand_addr(), rand_addr(),
               1'($urandom), {$urandom, $urandom},
               ($urandom_range(0, 1) == 1) ? '1
                                          : {$urandom, $urandom});
      end

      issue(0, 1, BASE, BASE + 64'h8, 0, 64'h0, '1);
      repeat (2) @(negedge clk);
      #2;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midop_reset");
      resp_q.delete();
      last_ls = 1'b0;
      repeat (2) @(negedge clk);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      rst_n = 1'b1;

      round(1, 1, BASE + 64'h4, BASE + 64'h8, 0, 64'h0, '1);
      round(1, 1, BASE + 64'h4, BASE + 64'h8, 0, 64'h0, '1);
      for (int i = 0; i < 20; i++) begin
         p = $urandom_range(0, 2);
         round(p != 1, p != 0, rand_addr(), rand_addr(),
               1'($urandom), {$urandom, $urandom}, '1);
      end

      repeat (5) @(negedge clk);
      chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
